downsample_engine: RTL and testbench

- Parametrised hardware successor to the instruction-driven downsampling processor; runs box-average image downsampling with no IRAM program.
- Reads a source image from DRAM, averages each FACTOR x FACTOR window, and writes one output pixel per window to a destination region.
- Sits beside the processor on the DRAM port. Arbitration between the two is external; the top-level mux uses busy.

---
 rtl/downsample_pkg.sv | 37 +++
 rtl/window_accumulator.sv | 54 +++++
 rtl/downsample_engine.sv | 186 ++++++++++++++++++
 tb/tb_downsample_engine.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/downsample_pkg.sv
// Shared types and helpers for the box-average downsampling engine.
// Holds the control state encoding, a constant log2 helper and the derived
// geometry for the default configuration (256x256 source, factor 2).
package downsample_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAST = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_e;

  // Ceiling log2, usable in constant expressions (exact for powers of two).
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Register width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v <= 1) ? 1 : log2c(v);
  endfunction

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_IMG_W  = 256;
  localparam int unsigned DEF_IMG_H  = 256;
  localparam int unsigned DEF_FACTOR = 2;

  localparam int unsigned OUT_W = DEF_IMG_W / DEF_FACTOR;
  localparam int unsigned OUT_H = DEF_IMG_H / DEF_FACTOR;
  localparam int unsigned WIN   = DEF_FACTOR * DEF_FACTOR;
  localparam int unsigned SUM_W = DEF_DATA_W + 2 * log2c(DEF_FACTOR);

endpackage

// File: rtl/window_accumulator.sv
// Window sum register with round-half-up average output.
// Latency: sum updates on the edge after clr/add; avg is combinational from the sum.
// Backpressure: none, the caller sequences clr/add one sample per cycle.
//
// Ports:
//   clock, reset_n : clock and async active-low reset
//   clr            : load zero (first read cycle of a window)
//   add            : add din to the running sum
//   din            : sample returned by DRAM
//   avg            : (sum + WIN/2) >> log2(WIN), truncated to DATA_W
module window_accumulator
  import downsample_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FACTOR = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] avg
);

  localparam int unsigned SHIFT = 2 * log2c(FACTOR);
  localparam int unsigned SUMW  = DATA_W + SHIFT;
  localparam int unsigned HALF  = (FACTOR * FACTOR) / 2;

  logic [SUMW-1:0] sum_q, sum_d;
  logic [SUMW-1:0] rounded;

  // The largest possible sum is (2^DATA_W - 1) * WIN, so adding WIN/2 still
  // fits in SUMW bits and the rounding term cannot overflow either.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + SUMW'(din);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign rounded = sum_q + SUMW'(HALF);
  assign avg     = DATA_W'(rounded >> SHIFT);

endmodule

// File: rtl/downsample_engine.sv
// Box-average image downsampler: reads FACTOR x FACTOR windows from DRAM and writes their mean.
// Latency: FACTOR*FACTOR+2 cycles per output pixel, plus one FIN cycle per job.
// Backpressure: none; owns the DRAM port while busy, external arbitration keys off busy.
//
// Ports:
//   clock, reset_n       : clock and async active-low reset
//   start, abort         : job request (IDLE only) and synchronous cancel
//   src_base, dst_base   : image base addresses, captured on start
//   DRAM_input_data      : read data, valid one cycle after DRAM_address
//   DRAM_address         : read/write address (holds its last value when not reading/writing)
//   DRAM_output_data     : write data, non-zero only in WR
//   write_DRAM           : write strobe, high only in WR
//   busy, done           : job in progress / one-cycle completion pulse
module downsample_engine
  import downsample_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned FACTOR = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DATA_W-1:0] DRAM_input_data,
  output logic [ADDR_W-1:0] DRAM_address,
  output logic [DATA_W-1:0] DRAM_output_data,
  output logic              write_DRAM,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OW   = IMG_W / FACTOR;
  localparam int unsigned OH   = IMG_H / FACTOR;
  localparam int unsigned NWIN = FACTOR * FACTOR;
  localparam int unsigned KW   = cnt_w(NWIN);
  localparam int unsigned XW   = cnt_w(OW);
  localparam int unsigned YW   = cnt_w(OH);

  if (!(FACTOR == 1 || FACTOR == 2 || FACTOR == 4 || FACTOR == 8)) begin : g_bad_factor
    $error("downsample_engine: FACTOR must be 1, 2, 4 or 8");
  end
  if ((IMG_W % FACTOR) != 0 || (IMG_H % FACTOR) != 0 || IMG_W == 0 || IMG_H == 0) begin : g_bad_img
    $error("downsample_engine: IMG_W and IMG_H must be non-zero multiples of FACTOR");
  end
  if (ADDR_W > 32 || ADDR_W == 0) begin : g_bad_addr
    $error("downsample_engine: ADDR_W must be 1..32");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [XW-1:0]     ox_q, ox_d;
  logic [YW-1:0]     oy_q, oy_d;
  logic [KW-1:0]     k_q, k_d;        // window sample index: kx = k % FACTOR, ky = k / FACTOR
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;  // last driven address, replayed outside RD/WR

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              acc_clr;
  logic [DATA_W-1:0] avg;

  // Offsets are formed in 32 bits and truncated, giving modulo-2^ADDR_W wrap.
  assign rd_addr = src_q + ADDR_W'(
                     (32'(oy_q) * FACTOR + 32'(k_q) / FACTOR) * IMG_W
                     + 32'(ox_q) * FACTOR + 32'(k_q) % FACTOR);
  assign wr_addr = dst_q + ADDR_W'(32'(oy_q) * OW + 32'(ox_q));

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    k_d          = k_q;
    rd_pend_d    = 1'b0;
    acc_clr      = 1'b0;
    DRAM_address = addr_q;
    write_DRAM   = 1'b0;
    done         = 1'b0;
    busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD;
          src_d   = src_base;
          dst_d   = dst_base;
          ox_d    = '0;
          oy_d    = '0;
          k_d     = '0;
        end
      end
      RD: begin
        DRAM_address = rd_addr;
        rd_pend_d    = 1'b1;
        // The cycle before a window's first read never issues a read, so
        // clearing here cannot drop a sample.
        acc_clr      = (k_q == '0);
        if (k_q == KW'(NWIN - 1)) begin
          k_d     = '0;
          state_d = LAST;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      LAST: begin
        state_d = WR;
      end
      WR: begin
        DRAM_address = wr_addr;
        write_DRAM   = 1'b1;
        state_d      = RD;
        if (ox_q == XW'(OW - 1)) begin
          ox_d = '0;
          if (oy_q == YW'(OH - 1)) begin
            state_d = FIN;
          end else begin
            oy_d = oy_q + YW'(1);
          end
        end else begin
          ox_d = ox_q + XW'(1);
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort only redirects the next state; a WR cycle's strobe above stands.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      rd_pend_d = 1'b0;
    end

    addr_d = DRAM_address;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      k_q       <= '0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      k_q       <= k_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
    end
  end

  // Read data lands one cycle after its address, so accumulation trails the
  // read by one cycle; LAST absorbs the final sample.
  window_accumulator #(
    .DATA_W (DATA_W),
    .FACTOR (FACTOR)
  ) u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .add     (rd_pend_q),
    .din     (DRAM_input_data),
    .avg     (avg)
  );

  assign DRAM_output_data = (state_q == WR) ? avg : '0;

endmodule

// File: tb/tb_downsample_engine.sv
module tb_downsample_engine;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // A: 4x4 factor 2, B: 8x8 factor 8, C: 4x4 factor 1 (copy)
  logic        start_a = 0, abort_a = 0, start_b = 0, start_c = 0;
  logic [15:0] src_a = 0, dst_a = 0, src_b = 0, dst_b = 0, src_c = 0, dst_c = 0;
  logic [7:0]  din_a, din_b, din_c, dout_a, dout_b, dout_c;
  logic [15:0] addr_a, addr_b, addr_c;
  logic        we_a, we_b, we_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

  downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(4), .IMG_H(4), .FACTOR(2)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .src_base(src_a), .dst_base(dst_a), .DRAM_input_data(din_a),
    .DRAM_address(addr_a), .DRAM_output_data(dout_a), .write_DRAM(we_a),
    .busy(busy_a), .done(done_a));

  downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(8), .IMG_H(8), .FACTOR(8)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .abort(1'b0),
    .src_base(src_b), .dst_base(dst_b), .DRAM_input_data(din_b),
    .DRAM_address(addr_b), .DRAM_output_data(dout_b), .write_DRAM(we_b),
    .busy(busy_b), .done(done_b));

  downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(4), .IMG_H(4), .FACTOR(1)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .start(start_c), .abort(1'b0),
    .src_base(src_c), .dst_base(dst_c), .DRAM_input_data(din_c),
    .DRAM_address(addr_c), .DRAM_output_data(dout_c), .write_DRAM(we_c),
    .busy(busy_c), .done(done_c));

  // Shared read-only image memory; writes are only logged.
  logic [7:0]  mem [0:65535];
  logic [23:0] wq_a[$], wq_b[$], wq_c[$], got_q[$];
  int busy_cnt[3] = '{0, 0, 0};
  int done_cnt[3] = '{0, 0, 0};

  always @(posedge clock) begin
    din_a <= mem[addr_a];
    din_b <= mem[addr_b];
    din_c <= mem[addr_c];
    if (we_a) wq_a.push_back({addr_a, dout_a});
    if (we_b) wq_b.push_back({addr_b, dout_b});
    if (we_c) wq_c.push_back({addr_c, dout_c});
    if (busy_a) busy_cnt[0]++;
    if (busy_b) busy_cnt[1]++;
    if (busy_c) busy_cnt[2]++;
    if (done_a) done_cnt[0]++;
    if (done_b) done_cnt[1]++;
    if (done_c) done_cnt[2]++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wq_size(input int which);
    if (which == 0) return wq_a.size();
    if (which == 1) return wq_b.size();
    return wq_c.size();
  endfunction

  task automatic grab(input int which, input int from);
    got_q.delete();
    for (int i = from; i < wq_size(which); i++) begin
      if (which == 0) got_q.push_back(wq_a[i]);
      else if (which == 1) got_q.push_back(wq_b[i]);
      else got_q.push_back(wq_c[i]);
    end
  endtask

  // Starts a job; returns on the falling edge right after start was sampled.
  task automatic kick(input int which, input logic [15:0] s, input logic [15:0] d);
    if (which == 0) begin src_a = s; dst_a = d; start_a = 1; end
    else if (which == 1) begin src_b = s; dst_b = d; start_b = 1; end
    else begin src_c = s; dst_c = d; start_c = 1; end
    @(negedge clock);
    start_a = 0; start_b = 0; start_c = 0;
  endtask

  task automatic wait_done(input int which, input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clock);
      if (which == 0) seen = done_a;
      else if (which == 1) seen = done_b;
      else seen = done_c;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    @(negedge clock);
  endtask

  // Reference: every output is the rounded mean of its source window.
  task automatic compare_job(input string tag, input int w, input int h, input int f,
                             input logic [15:0] src, input logic [15:0] dst);
    int ow, n;
    ow = w / f;
    n  = ow * (h / f);
    check({tag, " write count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      int ox, oy, sum;
      logic [15:0] a, ea;
      logic [7:0]  ed;
      ox = i % ow;
      oy = i / ow;
      sum = 0;
      for (int ky = 0; ky < f; ky++)
        for (int kx = 0; kx < f; kx++) begin
          a = 16'(int'(src) + (oy * f + ky) * w + ox * f + kx);
          sum += int'(mem[a]);
        end
      ed = 8'((sum + (f * f) / 2) / (f * f));
      ea = 16'(int'(dst) + oy * ow + ox);
      check($sformatf("%s px%0d addr", tag, i), 32'(got_q[i][23:8]), 32'(ea));
      check($sformatf("%s px%0d data", tag, i), 32'(got_q[i][7:0]), 32'(ed));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, b0, d0, n1;
    bit seen;
    logic [15:0] s, d;
    logic [15:0] wrap_exp [4];
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0002, 16'h0003};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // ---- reset state
    reset_n = 0;
    repeat (3) @(negedge clock);
    check("rst we_a", 32'(we_a), 0);
    check("rst busy_a", 32'(busy_a), 0);
    check("rst done_a", 32'(done_a), 0);
    check("rst addr_a", 32'(addr_a), 0);
    check("rst dout_a", 32'(dout_a), 0);
    check("rst busy_b", 32'(busy_b), 0);
    check("rst addr_c", 32'(addr_c), 0);
    reset_n = 1;
    @(negedge clock);

    // ---- constant image
    for (int i = 0; i < 16; i++) mem[16'h1000 + i] = 8'd100;
    n0 = wq_a.size(); b0 = busy_cnt[0]; d0 = done_cnt[0];
    kick(0, 16'h1000, 16'h2000);
    wait_done(0, "const", 100);
    check("const busy low after FIN", 32'(busy_a), 0);
    check("const done low after FIN", 32'(done_a), 0);
    check("const done pulses", 32'(done_cnt[0] - d0), 1);
    check("const busy cycles", 32'(busy_cnt[0] - b0), 25);
    grab(0, n0);
    check("const px0 is 100", 32'(got_q[0][7:0]), 100);
    compare_job("const", 4, 4, 2, 16'h1000, 16'h2000);
    check("const addr holds in IDLE", 32'(addr_a), 32'h2003);

    // ---- rounding windows
    mem[16'h3000] = 1; mem[16'h3001] = 2; mem[16'h3004] = 2; mem[16'h3005] = 2;
    mem[16'h3002] = 1; mem[16'h3003] = 1; mem[16'h3006] = 1; mem[16'h3007] = 2;
    n0 = wq_a.size();
    kick(0, 16'h3000, 16'h2100);
    wait_done(0, "round", 100);
    grab(0, n0);
    check("round sum7 -> 2", 32'(got_q[0][7:0]), 2);
    check("round sum5 -> 1", 32'(got_q[1][7:0]), 1);
    compare_job("round", 4, 4, 2, 16'h3000, 16'h2100);

    // ---- random jobs
    for (int j = 0; j < 3; j++) begin
      s = 16'($urandom); d = 16'($urandom);
      n0 = wq_a.size();
      kick(0, s, d);
      wait_done(0, $sformatf("rand%0d", j), 100);
      grab(0, n0);
      compare_job($sformatf("rand%0d", j), 4, 4, 2, s, d);
    end

    // ---- source address wrap
    n0 = wq_a.size();
    kick(0, 16'hFFFE, 16'h4000);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("wrap rd%0d", j), 32'(addr_a), 32'(wrap_exp[j]));
      @(negedge clock);
    end
    wait_done(0, "wrap", 100);
    grab(0, n0);
    compare_job("wrap", 4, 4, 2, 16'hFFFE, 16'h4000);

    // ---- start while busy is ignored
    n0 = wq_a.size();
    kick(0, 16'h1000, 16'h2000);
    repeat (5) @(negedge clock);
    src_a = 16'h5000; dst_a = 16'h6000; start_a = 1;
    @(negedge clock);
    start_a = 0;
    wait_done(0, "restart", 100);
    grab(0, n0);
    compare_job("restart", 4, 4, 2, 16'h1000, 16'h2000);

    // ---- start and abort together in IDLE: start wins
    n0 = wq_a.size();
    src_a = 16'h3000; dst_a = 16'h2400; start_a = 1; abort_a = 1;
    @(negedge clock);
    start_a = 0; abort_a = 0;
    check("start beats abort", 32'(busy_a), 1);
    wait_done(0, "startabort", 100);
    grab(0, n0);
    compare_job("startabort", 4, 4, 2, 16'h3000, 16'h2400);

    // ---- abort in RD of the second window
    n0 = wq_a.size(); d0 = done_cnt[0];
    kick(0, 16'h3000, 16'h2500);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (we_a) seen = 1; else @(negedge clock);
    end
    check("abort first write seen", 32'(seen), 1);
    @(negedge clock);
    abort_a = 1;
    @(negedge clock);
    abort_a = 0;
    check("abort busy falls", 32'(busy_a), 0);
    repeat (10) @(negedge clock);
    check("abort write count", 32'(wq_a.size() - n0), 1);
    check("abort no done", 32'(done_cnt[0] - d0), 0);
    grab(0, n0);
    check("abort write addr", 32'(got_q[0][23:8]), 32'h2500);

    // ---- reset during WR
    kick(0, 16'h1000, 16'h2200);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (we_a) seen = 1; else @(negedge clock);
    end
    check("rstmid WR reached", 32'(seen), 1);
    #1 reset_n = 0;
    n1 = wq_a.size();
    #1;
    check("rstmid we", 32'(we_a), 0);
    check("rstmid busy", 32'(busy_a), 0);
    check("rstmid done", 32'(done_a), 0);
    repeat (3) @(negedge clock);
    check("rstmid no write", 32'(wq_a.size() - n1), 0);
    reset_n = 1;
    @(negedge clock);
    n0 = wq_a.size();
    kick(0, 16'h3000, 16'h2300);
    wait_done(0, "after rst", 100);
    grab(0, n0);
    compare_job("after rst", 4, 4, 2, 16'h3000, 16'h2300);

    // ---- factor 8, all-max window
    for (int i = 0; i < 64; i++) mem[16'h7000 + i] = 8'hFF;
    n0 = wq_b.size(); b0 = busy_cnt[1];
    kick(1, 16'h7000, 16'h8000);
    wait_done(1, "max8", 200);
    check("max8 busy cycles", 32'(busy_cnt[1] - b0), 67);
    grab(1, n0);
    check("max8 value", 32'(got_q[0][7:0]), 32'hFF);
    compare_job("max8", 8, 8, 8, 16'h7000, 16'h8000);
    s = 16'($urandom); d = 16'($urandom);
    n0 = wq_b.size();
    kick(1, s, d);
    wait_done(1, "rand8", 200);
    grab(1, n0);
    compare_job("rand8", 8, 8, 8, s, d);

    // ---- factor 1 copy mode
    s = 16'($urandom); d = 16'($urandom);
    n0 = wq_c.size(); b0 = busy_cnt[2];
    kick(2, s, d);
    wait_done(2, "copy", 200);
    check("copy busy cycles", 32'(busy_cnt[2] - b0), 49);
    grab(2, n0);
    compare_job("copy", 4, 4, 1, s, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
